// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps a 2-input gate through {a,b}=00..11 and compares its output with EXPECTED_TT.
// Optional GATE_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_truth_checker #(
  parameter logic [3:0] EXPECTED_TT = 4'b0001,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic drv_a_n, drv_b_n, busy_n, done_n, pass_n, mis, stop;
  logic [2:0] err_cnt_n;
  logic [3:0] fail_vec_n;
  // 4-state compare so an X/Z from the gate under check counts as a mismatch
  assign mis = dut_y !== EXPECTED_TT[idx];
`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign stop = mis;
`else
  assign stop = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      drv_a    <= 1'b0;
      drv_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      drv_a    <= drv_a_n;
      drv_b    <= drv_b_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      err_cnt  <= err_cnt_n;
      fail_vec <= fail_vec_n;
    end
  end
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    drv_a_n    = drv_a;
    drv_b_n    = drv_b;
    busy_n     = busy;
    done_n     = 1'b0;
    pass_n     = pass;
    err_cnt_n  = err_cnt;
    fail_vec_n = fail_vec;
    case (state)
      IDLE: if (start) begin
        state_n    = SETTLE;
        idx_n      = '0;
        cnt_n      = CNT_LOAD;
        drv_a_n    = 1'b0;
        drv_b_n    = 1'b0;
        busy_n     = 1'b1;
        pass_n     = 1'b0;
        err_cnt_n  = '0;
        fail_vec_n = '0;
      end
      SETTLE: begin
        state_n = cnt == '0 ? SAMPLE : SETTLE;
        cnt_n   = cnt == '0 ? cnt : cnt - CW'(1);
      end
      SAMPLE: begin
        err_cnt_n       = err_cnt + {2'b00, mis};
        fail_vec_n[idx] = fail_vec[idx] | mis;
        if (idx == 2'd3 || stop) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = err_cnt_n == 3'd0;
        end else begin
          state_n            = SETTLE;
          idx_n              = idx + 2'd1;
          {drv_a_n, drv_b_n} = idx + 2'd1;
          cnt_n              = CNT_LOAD;
        end
      end
      DONE: begin
        state_n = IDLE;
        drv_a_n = 1'b0;
        drv_b_n = 1'b0;
      end
    endcase
  end
endmodule
